// File: rtl/ball_hit_renderer.sv
// ball_hit_renderer: Avalon-MM ball registers with vsync commit and a 2-stage pixel hit test
module ball_hit_renderer #(
    parameter int NUM_BALLS = 4,
    parameter int ID_W      = 2,
    parameter int COORD_W   = 10,
    parameter int RAD_W     = 6
) (
    input  logic               Clk,
    input  logic               Reset_n,
    input  logic [3:0]         avs_address,
    input  logic               avs_write,
    input  logic [31:0]        avs_writedata,
    input  logic               avs_read,
    output logic [31:0]        avs_readdata,
    input  logic               VGA_VS,
    input  logic [COORD_W-1:0] DrawX,
    input  logic [COORD_W-1:0] DrawY,
    output logic               is_ball,
    output logic [ID_W-1:0]    ballID,
    output logic               frame_irq
);
    localparam int SQ_W = 2 * COORD_W;
    localparam int R2_W = 2 * RAD_W;

    logic [31:0]        sh [NUM_BALLS];
    logic [COORD_W-1:0] act_x [NUM_BALLS];
    logic [COORD_W-1:0] act_y [NUM_BALLS];
    logic [RAD_W-1:0]   act_r [NUM_BALLS];
    logic [NUM_BALLS-1:0] act_en;
    logic               pending, vs_d;
    logic [ID_W-1:0]    idx;
    logic               ball_wr, ctrl_wr, commit;
    logic [31:0]        rd_word;
    logic [SQ_W-1:0]    dx2_c [NUM_BALLS];
    logic [SQ_W-1:0]    dy2_c [NUM_BALLS];
    logic [R2_W-1:0]    r2_c  [NUM_BALLS];
    logic [SQ_W-1:0]    dx2_q [NUM_BALLS];
    logic [SQ_W-1:0]    dy2_q [NUM_BALLS];
    logic [R2_W-1:0]    r2_q  [NUM_BALLS];
    logic [NUM_BALLS-1:0] en_q, hit;
    logic [ID_W-1:0]    hit_id;

    assign idx     = avs_address[ID_W-1:0];
    assign ball_wr = avs_write && (avs_address < 4'(NUM_BALLS));
    assign ctrl_wr = avs_write && (avs_address == 4'(NUM_BALLS));
    assign commit  = vs_d & ~VGA_VS & pending;

    // Shadow words take writes; active fields are copied from the pre-write shadow on a commit edge
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            for (int i = 0; i < NUM_BALLS; i++) begin
                sh[i]    <= '0;
                act_x[i] <= '0;
                act_y[i] <= '0;
                act_r[i] <= '0;
            end
            act_en    <= '0;
            pending   <= 1'b0;
            frame_irq <= 1'b0;
            vs_d      <= 1'b1;
        end else begin
            vs_d <= VGA_VS;
            if (ball_wr)
                sh[idx] <= avs_writedata;
            if (commit)
                for (int i = 0; i < NUM_BALLS; i++) begin
                    act_x[i]  <= sh[i][COORD_W-1:0];
                    act_y[i]  <= sh[i][2*COORD_W-1:COORD_W];
                    act_r[i]  <= sh[i][2*COORD_W+RAD_W-1:2*COORD_W];
                    act_en[i] <= sh[i][31];
                end
            pending   <= (ctrl_wr && avs_writedata[0]) ? 1'b1 : commit ? 1'b0 : pending;
            frame_irq <= commit ? 1'b1 : (ctrl_wr && avs_writedata[1]) ? 1'b0 : frame_irq;
        end
    end

    // Read mux: shadow word, CTRL status, or zero for unmapped addresses
    always_comb begin
        rd_word = '0;
        if (avs_address < 4'(NUM_BALLS))
            rd_word = sh[idx];
        else if (avs_address == 4'(NUM_BALLS))
            rd_word[1:0] = {frame_irq, pending};
    end

    // Read data is captured one Clk after the strobe and held until the next read
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n)
            avs_readdata <= '0;
        else if (avs_read)
            avs_readdata <= rd_word;
    end

    // Per-ball squared offsets using the magnitude of the signed difference
    for (genvar g = 0; g < NUM_BALLS; g++) begin : g_sq
        logic [COORD_W:0]   dx, dy;
        logic [COORD_W-1:0] adx, ady;
        assign dx  = {1'b0, DrawX} - {1'b0, act_x[g]};
        assign dy  = {1'b0, DrawY} - {1'b0, act_y[g]};
        assign adx = dx[COORD_W] ? ~dx[COORD_W-1:0] + 1'b1 : dx[COORD_W-1:0];
        assign ady = dy[COORD_W] ? ~dy[COORD_W-1:0] + 1'b1 : dy[COORD_W-1:0];
        assign dx2_c[g] = {{COORD_W{1'b0}}, adx} * {{COORD_W{1'b0}}, adx};
        assign dy2_c[g] = {{COORD_W{1'b0}}, ady} * {{COORD_W{1'b0}}, ady};
        assign r2_c[g]  = {{RAD_W{1'b0}}, act_r[g]} * {{RAD_W{1'b0}}, act_r[g]};
    end

    // Stage 1: register squares together with radius and enable so each pixel sees one coherent ball set
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            for (int i = 0; i < NUM_BALLS; i++) begin
                dx2_q[i] <= '0;
                dy2_q[i] <= '0;
                r2_q[i]  <= '0;
            end
            en_q <= '0;
        end else begin
            for (int i = 0; i < NUM_BALLS; i++) begin
                dx2_q[i] <= dx2_c[i];
                dy2_q[i] <= dy2_c[i];
                r2_q[i]  <= r2_c[i];
            end
            en_q <= act_en;
        end
    end

    // Distance compare at full width, then pick the lowest-numbered covering ball
    always_comb begin
        hit    = '0;
        hit_id = '0;
        for (int i = 0; i < NUM_BALLS; i++)
            hit[i] = en_q[i] && (({1'b0, dx2_q[i]} + {1'b0, dy2_q[i]}) <= (SQ_W+1)'(r2_q[i]));
        for (int i = NUM_BALLS - 1; i >= 0; i--)
            if (hit[i])
                hit_id = ID_W'(i);
    end

    // Stage 2: register pixel outputs
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            is_ball <= 1'b0;
            ballID  <= '0;
        end else begin
            is_ball <= |hit;
            ballID  <= hit_id;
        end
    end
endmodule
